// File: rtl/mark_bank.sv
// rtl/mark_bank.sv - multi-row board-mark store with row/cell writes and a row-by-row stream-out
module mark_bank #(
    parameter int SECTION_SIZE = 19,
    parameter int NUM_ROWS     = 19,
    parameter int ROW_AW       = 5,
    parameter int COL_AW       = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [ROW_AW-1:0]       wr_row,
    input  logic [SECTION_SIZE-1:0] wr_data,
    input  logic                    set_en,
    input  logic [ROW_AW-1:0]       set_row,
    input  logic [COL_AW-1:0]       set_col,
    input  logic                    set_val,
    input  logic                    rd_start,
    output logic                    rd_busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ROW_AW-1:0]       out_row,
    output logic [SECTION_SIZE-1:0] out_data,
    output logic                    out_last
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SECTION_SIZE-1:0] rows      [NUM_ROWS];
    logic [SECTION_SIZE-1:0] rows_next [NUM_ROWS];
    logic                    cap;
    logic                    done;
    logic [ROW_AW-1:0]       cap_row;
    logic [SECTION_SIZE-1:0] cap_data;

    // Next row contents: whole-row load first, then the cell write on top.
    // Column c lives at bit SECTION_SIZE-1-c so column 0 is the MSB.
    // Out-of-range indices match no row/column and so fall away naturally.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            rows_next[r] = rows[r];
            if (wr_en && wr_row == ROW_AW'(r)) begin
                rows_next[r] = wr_data;
            end
            if (set_en && set_row == ROW_AW'(r)) begin
                for (int c = 0; c < SECTION_SIZE; c++) begin
                    if (set_col == COL_AW'(c)) begin
                        rows_next[r][SECTION_SIZE-1-c] = set_val;
                    end
                end
            end
        end
    end

    // Row storage: reset and clear both wipe the bank and drop same-cycle writes.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (rst || clr) begin
                rows[r] <= '0;
            end else begin
                rows[r] <= rows_next[r];
            end
        end
    end

    // Pre-edge contents of the row about to be captured into the beat.
    always_comb begin
        cap_data = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (cap_row == ROW_AW'(r)) begin
                cap_data = rows[r];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus capture/finish decisions for the stream registers.
    always_comb begin
        state_next = state;
        cap        = 1'b0;
        done       = 1'b0;
        cap_row    = '0;
        case (state)
            IDLE: begin
                if (rd_start && !clr) begin
                    state_next = STREAM;
                    cap        = 1'b1;
                end
            end
            STREAM: begin
                if (clr) begin
                    state_next = IDLE;
                end else if (out_ready) begin
                    if (out_last) begin
                        state_next = IDLE;
                        done       = 1'b1;
                    end else begin
                        cap     = 1'b1;
                        cap_row = out_row + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat registers: a captured beat is a snapshot and holds until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            out_data  <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (cap) begin
            out_valid <= 1'b1;
            out_row   <= cap_row;
            out_data  <= cap_data;
            out_last  <= (cap_row == ROW_AW'(NUM_ROWS - 1));
        end else if (done) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    assign rd_busy = (state == STREAM);

endmodule

// File: tb/tb_mark_bank.sv
// tb/tb_mark_bank.sv - scoreboard bench for mark_bank at default and reduced parameters
module tb_mark_bank;

    typedef struct {
        logic [31:0] row;
        logic [31:0] data;
        logic [31:0] last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    logic        a_clr, a_wr_en, a_set_en, a_set_val, a_rd_start, a_out_ready;
    logic [4:0]  a_wr_row, a_set_row, a_set_col;
    logic [18:0] a_wr_data;
    logic        a_rd_busy, a_out_valid, a_out_last;
    logic [4:0]  a_out_row;
    logic [18:0] a_out_data;

    logic        b_clr, b_wr_en, b_set_en, b_set_val, b_rd_start, b_out_ready;
    logic [2:0]  b_wr_row, b_set_row, b_set_col;
    logic [5:0]  b_wr_data;
    logic        b_rd_busy, b_out_valid, b_out_last;
    logic [2:0]  b_out_row;
    logic [5:0]  b_out_data;

    logic [18:0] model_a [19];
    logic [5:0]  model_b [4];
    beat_t       qa[$];
    beat_t       qb[$];
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    mark_bank dut_a (
        .clk(clk), .rst(rst), .clr(a_clr),
        .wr_en(a_wr_en), .wr_row(a_wr_row), .wr_data(a_wr_data),
        .set_en(a_set_en), .set_row(a_set_row), .set_col(a_set_col), .set_val(a_set_val),
        .rd_start(a_rd_start), .rd_busy(a_rd_busy), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_row(a_out_row), .out_data(a_out_data),
        .out_last(a_out_last)
    );

    mark_bank #(.SECTION_SIZE(6), .NUM_ROWS(4), .ROW_AW(3), .COL_AW(3)) dut_b (
        .clk(clk), .rst(rst), .clr(b_clr),
        .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_data(b_wr_data),
        .set_en(b_set_en), .set_row(b_set_row), .set_col(b_set_col), .set_val(b_set_val),
        .rd_start(b_rd_start), .rd_busy(b_rd_busy), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_row(b_out_row), .out_data(b_out_data),
        .out_last(b_out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_a();
        for (int r = 0; r < 19; r++) begin
            qa.push_back('{row: 32'(r), data: 32'(model_a[r]), last: 32'(r == 18)});
        end
    endtask

    task automatic push_b();
        for (int r = 0; r < 4; r++) begin
            qb.push_back('{row: 32'(r), data: 32'(model_b[r]), last: 32'(r == 3)});
        end
    endtask

    // Score any beat accepted at the coming edge, then advance one cycle.
    task automatic tick();
        beat_t e;
        if (a_out_valid && a_out_ready) begin
            chk("a_beat_expected", 32'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_row", 32'(a_out_row), e.row);
                chk("a_data", 32'(a_out_data), e.data);
                chk("a_last", 32'(a_out_last), e.last);
            end
        end
        if (b_out_valid && b_out_ready) begin
            chk("b_beat_expected", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_row", 32'(b_out_row), e.row);
                chk("b_data", 32'(b_out_data), e.data);
                chk("b_last", 32'(b_out_last), e.last);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input int exp_len);
        int n = 0;
        while (a_rd_busy && n < 100) begin
            tick();
            n++;
        end
        chk("a_stream_len", 32'(n), 32'(exp_len));
        chk("a_queue_drained", 32'(qa.size()), 0);
    endtask

    task automatic run_b(input int exp_len);
        int n = 0;
        while (b_rd_busy && n < 100) begin
            tick();
            n++;
        end
        chk("b_stream_len", 32'(n), 32'(exp_len));
        chk("b_queue_drained", 32'(qb.size()), 0);
    endtask

    initial begin
        rst = 1'b1;
        a_clr = 0; a_set_en = 0; a_set_val = 0; a_rd_start = 0; a_out_ready = 0;
        a_set_row = 0; a_set_col = 0;
        a_wr_en = 1; a_wr_row = 5'd3; a_wr_data = '1;
        b_clr = 0; b_wr_en = 0; b_set_en = 0; b_set_val = 0; b_rd_start = 0; b_out_ready = 0;
        b_wr_row = 0; b_set_row = 0; b_set_col = 0; b_wr_data = 0;
        for (int r = 0; r < 19; r++) model_a[r] = '0;
        for (int r = 0; r < 4; r++) model_b[r] = '0;

        // Reset with a competing row write
        tick(); tick();
        rst = 0; a_wr_en = 0;
        tick();
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_rd_busy", 32'(a_rd_busy), 0);
        chk("rst_out_row", 32'(a_out_row), 0);
        chk("rst_out_data", 32'(a_out_data), 0);
        chk("rst_out_last", 32'(a_out_last), 0);
        chk("rst_b_out_valid", 32'(b_out_valid), 0);

        // Row loads, then a full stream under continuous ready
        a_wr_en = 1; a_wr_row = 5'd0; a_wr_data = 19'h40001; tick();
        a_wr_row = 5'd18; a_wr_data = 19'h00001; tick();
        a_wr_en = 0;
        model_a[0] = 19'h40001; model_a[18] = 19'h00001;
        a_out_ready = 1; a_rd_start = 1; push_a();
        tick();
        a_rd_start = 0;
        chk("first_beat_valid", 32'(a_out_valid), 1);
        chk("first_beat_busy", 32'(a_rd_busy), 1);
        run_a(19);
        chk("end_out_valid", 32'(a_out_valid), 0);
        chk("end_out_last", 32'(a_out_last), 0);
        chk("end_out_row_held", 32'(a_out_row), 18);
        chk("end_out_data_held", 32'(a_out_data), 32'h00001);

        // Cell ops: same-row collision, out-of-range column/row, cross-row pair, clear bit
        a_wr_en = 1; a_wr_row = 5'd5; a_wr_data = '0;
        a_set_en = 1; a_set_row = 5'd5; a_set_col = 5'd2; a_set_val = 1;
        tick();
        model_a[5] = 19'h10000;
        a_wr_en = 0; a_set_col = 5'd19; tick();
        a_set_row = 5'd19; a_set_col = 5'd0; tick();
        a_wr_en = 1; a_wr_row = 5'd6; a_wr_data = 19'h00007;
        a_set_row = 5'd7; a_set_col = 5'd18; a_set_val = 1;
        tick();
        model_a[6] = 19'h00007; model_a[7] = 19'h00001;
        a_wr_en = 0; a_set_row = 5'd0; a_set_col = 5'd0; a_set_val = 0;
        tick();
        model_a[0] = 19'h00001;
        a_set_en = 0;

        // Backpressure: row 4 beat stays a snapshot while row 4 is overwritten
        a_rd_start = 1; push_a(); tick(); a_rd_start = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_row_shown", 32'(a_out_row), 4);
        a_out_ready = 0; a_wr_en = 1; a_wr_row = 5'd4; a_wr_data = '1;
        tick();
        a_wr_en = 0; model_a[4] = '1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_row", 32'(a_out_row), 4);
            chk("bp_hold_data", 32'(a_out_data), 0);
            chk("bp_hold_valid", 32'(a_out_valid), 1);
            if (i < 2) tick();
        end
        a_out_ready = 1;
        tick();
        chk("bp_release_row", 32'(a_out_row), 5);
        run_a(14);

        // Abort with clr during the row 7 beat
        a_rd_start = 1; push_a(); tick(); a_rd_start = 0;
        for (int i = 0; i < 7; i++) tick();
        chk("abort_row_shown", 32'(a_out_row), 7);
        a_out_ready = 0; a_clr = 1;
        tick();
        a_clr = 0; qa.delete();
        for (int r = 0; r < 19; r++) model_a[r] = '0;
        chk("abort_out_valid", 32'(a_out_valid), 0);
        chk("abort_rd_busy", 32'(a_rd_busy), 0);
        a_out_ready = 1; a_rd_start = 1; push_a(); tick(); a_rd_start = 0;
        run_a(19);

        // Reduced parameters: out-of-range row/column ignored, last on row 3
        b_wr_en = 1; b_wr_row = 3'd4; b_wr_data = 6'h3F; tick();
        b_wr_en = 0; b_set_en = 1; b_set_row = 3'd1; b_set_col = 3'd6; b_set_val = 1; tick();
        b_set_col = 3'd5; b_wr_en = 1; b_wr_row = 3'd3; b_wr_data = 6'h21; tick();
        b_set_en = 0; b_wr_en = 0;
        model_b[1] = 6'h01; model_b[3] = 6'h21;
        b_out_ready = 1; b_rd_start = 1; push_b(); tick(); b_rd_start = 0;
        run_b(4);
        chk("b_end_row_held", 32'(b_out_row), 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mark_bank.md
Name: mark_bank

Overview:
- Parametrised multi-row board-mark store; one SECTION_SIZE-bit mark vector per board row.
- Supports whole-row loads, single-cell set/clear and a global clear.
- Streams the whole bank out row by row over a valid/ready interface.
- Sits between the move-placement logic and the downstream scoring/threat-scan stream stage.

Parameters:
- SECTION_SIZE, 19, bits per row (board columns).
- NUM_ROWS, 19, number of rows held (board rows).
- ROW_AW, 5, row index width; must satisfy 2**ROW_AW >= NUM_ROWS.
- COL_AW, 5, column index width; must satisfy 2**COL_AW >= SECTION_SIZE.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of all rows; aborts any stream.
- wr_en  in  1  whole-row load strobe.
- wr_row  in  ROW_AW  row index for wr_en.
- wr_data  in  SECTION_SIZE  row value, bit 0 = column 0 (MSB-first vector [0:SECTION_SIZE-1]).
- set_en  in  1  single-cell write strobe.
- set_row  in  ROW_AW  row index for set_en.
- set_col  in  COL_AW  column index for set_en.
- set_val  in  1  value written to the cell (1 = mark, 0 = unmark).
- rd_start  in  1  start a full-bank stream.
- rd_busy  out  1  high while in STREAM state.
- out_valid  out  1  out_row/out_data/out_last valid.
- out_ready  in  1  downstream accept.
- out_row  out  ROW_AW  row index of out_data.
- out_data  out  SECTION_SIZE  row contents.
- out_last  out  1  high with the row NUM_ROWS-1 beat.

Behaviour:
- Reset (rst=1 at edge): all rows 0; state IDLE; rd_busy 0, out_valid 0, out_row 0, out_data 0, out_last 0. rst overrides every other input.
- Write priority per edge: rst > clr > writes.
  - clr=1: all rows become 0; wr_en/set_en in that cycle are discarded.
- Row writes:
  - wr_en with wr_row < NUM_ROWS: row <= wr_data.
  - wr_en and set_en to the same row in one cycle: start from wr_data, then apply the set_en cell write (cell write wins on its bit).
  - wr_en and set_en to different rows: both take effect.
- Cell writes:
  - set_en with set_row < NUM_ROWS and set_col < SECTION_SIZE: the single bit is updated; other bits unchanged.
- Out-of-range row or column index: that write is ignored silently; no other row is affected.
- Storage and stream registers update only in their own FSM branch; no combinational path from inputs to outputs.
- FSM states: IDLE, STREAM.
- IDLE:
  - rd_start=1 (and clr=0) -> STREAM. At the same edge: out_data <= row 0 pre-edge contents, out_row <= 0, out_valid <= 1, out_last <= (NUM_ROWS==1).
  - Latency: rd_start at cycle N -> first beat visible in cycle N+1.
- STREAM:
  - rd_busy=1; rd_start ignored.
  - out_valid & !out_ready: out_row/out_data/out_last held stable, even if the stored row changes meanwhile (snapshot semantics per beat).
  - out_valid & out_ready & !out_last: load the next row index and that row's pre-edge contents; out_valid stays 1. This gives one beat per cycle under continuous ready.
  - out_valid & out_ready & out_last: -> IDLE; out_valid, out_last, rd_busy go 0 next cycle; out_data/out_row keep their last values.
- Write/stream interaction: a write committed at the same edge a row is captured is not seen by that beat. It is seen if that row is captured at a later edge.
- clr in STREAM: storage cleared, FSM -> IDLE, out_valid 0 next cycle. The beat pending in that cycle is not considered accepted.
- rst mid-stream: identical to reset; no partial beat remains.
- Minimum stream duration: NUM_ROWS cycles under continuous ready; ready stalls extend it one cycle per stalled cycle.

Test Plan:
- Reset/idle: rst 2 cycles with wr_en=1 wr_row=3 wr_data=all-ones -> all rows 0; out_valid=0, rd_busy=0 after reset.
- Row load + stream: write row 0=19'h40001 (bits 0 and 18), row 18=19'h00001; rd_start with out_ready=1 -> 19 consecutive beats. Row 0 data=19'h40001, rows 1-17=0, row 18 data=19'h00001 with out_last=1. rd_busy drops on the cycle after the last beat.
- Cell ops and collision: wr_en row 5 = 0 and set_en row 5 col 2 val 1 in the same cycle -> row 5 = 19'h10000 (bit 2 only). Then set_col=19 (out of range) -> no change.
- Backpressure snapshot: stream with out_ready=0 while beat for row 4 is shown; write row 4 = all-ones; hold 3 cycles -> out_data stays old value (0). Release ready -> row 5 beat next cycle.
- Abort: clr asserted during row-7 beat -> out_valid=0 next cycle, all rows 0. A new rd_start streams 19 zero rows.
- Reduced parameters: SECTION_SIZE=6, NUM_ROWS=4 -> out_last on row 3; set_col=6 and wr_row=4 ignored.
